// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter_if: ibus/dbus request+response and downstream port  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
);
  logic                  ireq_valid;
  logic [ADDR_W-1:0]     ireq_addr;
  logic                  iresp_addr_ok;
  logic                  iresp_data_ok;
  logic [INST_W-1:0]     iresp_data;

  logic                  dreq_valid;
  logic [ADDR_W-1:0]     dreq_addr;
  logic [2:0]            dreq_size;
  logic [DATA_W/8-1:0]   dreq_strobe;
  logic [DATA_W-1:0]     dreq_data;
  logic                  dresp_addr_ok;
  logic                  dresp_data_ok;
  logic [DATA_W-1:0]     dresp_data;

  logic                  mreq_valid;
  logic                  mreq_ready;
  logic [ADDR_W-1:0]     mreq_addr;
  logic [2:0]            mreq_size;
  logic [DATA_W/8-1:0]   mreq_strobe;
  logic [DATA_W-1:0]     mreq_wdata;
  logic                  mresp_valid;
  logic [DATA_W-1:0]     mresp_data;

  // Arbiter side: serves the core buses and drives the memory port.
  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_wdata,
    input  mreq_ready, mresp_valid, mresp_data
  );

  // Environment side: core requesters plus the memory/cache.
  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_wdata,
    output mreq_ready, mresp_valid, mresp_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter: one-outstanding ibus/dbus arbiter for a memory port |
// | Optional macro ARB_ROUND_ROBIN_EN: round-robin instead of dbus-first. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mem_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e               state_q;
  logic                 owner_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 isel_q;
  logic                 idok_q;
  logic                 ddok_q;

  logic                 owner_valid;
  logic                 req_active;
  logic                 handshake;
  logic                 grant_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d;

  assign owner_valid = owner_q ? bus.dreq_valid : bus.ireq_valid;
  assign req_active  = (state_q == S_REQ) && owner_valid;
  assign handshake   = req_active && bus.mreq_ready;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q;
  // rr_last_q names the bus served last; on contention the other one wins.
  assign grant_d = (bus.dreq_valid && bus.ireq_valid) ? ~rr_last_q : bus.dreq_valid;
`else
  assign grant_d = bus.dreq_valid;
`endif

  assign addr_d  = owner_q ? bus.dreq_addr : bus.ireq_addr;
  assign wdata_d = owner_q ? bus.dreq_data : '0;

  assign bus.mreq_valid  = req_active;
  assign bus.mreq_addr   = req_active ? addr_d : '0;
  assign bus.mreq_size   = req_active ? (owner_q ? bus.dreq_size : 3'd2) : 3'd0;
  assign bus.mreq_strobe = (req_active && owner_q) ? bus.dreq_strobe : '0;
  assign bus.mreq_wdata  = req_active ? wdata_d : '0;

  assign bus.iresp_addr_ok = handshake && !owner_q;
  assign bus.dresp_addr_ok = handshake && owner_q;
  assign bus.iresp_data_ok = idok_q;
  assign bus.dresp_data_ok = ddok_q;
  assign bus.iresp_data    = isel_q ? rdata_q[DATA_W-1 -: INST_W] : rdata_q[INST_W-1:0];
  assign bus.dresp_data    = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      rdata_q   <= '0;
      isel_q    <= 1'b0;
      idok_q    <= 1'b0;
      ddok_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q <= 1'b0;
`endif
    end else begin
      idok_q <= 1'b0;
      ddok_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.dreq_valid || bus.ireq_valid) begin
            owner_q <= grant_d;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (!owner_valid) begin
            state_q <= S_IDLE;
          end else if (bus.mreq_ready) begin
            if (!owner_q) isel_q <= bus.ireq_addr[2];
            // A response in the acceptance cycle skips WAIT entirely.
            if (bus.mresp_valid) begin
              rdata_q <= bus.mresp_data;
              idok_q  <= !owner_q;
              ddok_q  <= owner_q;
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.mresp_valid) begin
            rdata_q <= bus.mresp_data;
            idok_q  <= !owner_q;
            ddok_q  <= owner_q;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_q <= owner_q;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed stimulus with a response scoreboard     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_W(INST_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_W(INST_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void push(bit d, bit c, logic [63:0] v);
    exp_t e;
    e.is_d = d;
    e.chk_data = c;
    e.data = v;
    exp_q.push_back(e);
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Response monitor: every data_ok must match the oldest expected response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.iresp_data_ok === 1'b1 || bus.dresp_data_ok === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_data_ok", {62'd0, bus.dresp_data_ok, bus.iresp_data_ok}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port", {62'd0, bus.dresp_data_ok, bus.iresp_data_ok}, e.is_d ? 64'd2 : 64'd1);
        if (e.chk_data) begin
          if (e.is_d) chk("dresp_data", bus.dresp_data, e.data);
          else        chk("iresp_data", {32'd0, bus.iresp_data}, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.ireq_valid = 1'b0; bus.ireq_addr = '0;
    bus.dreq_valid = 1'b0; bus.dreq_addr = '0; bus.dreq_size = 3'd0;
    bus.dreq_strobe = '0; bus.dreq_data = '0;
    bus.mreq_ready = 1'b0; bus.mresp_valid = 1'b0; bus.mresp_data = '0;

    // Reset state
    nxt(); nxt();
    smp();
    chk("rst_mreq_valid", bus.mreq_valid, 0);
    chk("rst_mreq_addr", bus.mreq_addr, 0);
    chk("rst_dresp_data", bus.dresp_data, 0);
    chk("rst_iresp_data", bus.iresp_data, 0);
    chk("rst_data_ok", {bus.iresp_data_ok, bus.dresp_data_ok}, 0);
    nxt();
    rst_n = 1'b1;
    nxt();

    // Single fetch, upper word selected by addr[2]
    bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0004; bus.mreq_ready = 1'b1;
    smp(); chk("fetch_idle_mreq_valid", bus.mreq_valid, 0);
    nxt();
    smp();
    chk("fetch_mreq_valid", bus.mreq_valid, 1);
    chk("fetch_mreq_addr", bus.mreq_addr, 64'h8000_0004);
    chk("fetch_mreq_size", bus.mreq_size, 2);
    chk("fetch_mreq_strobe", bus.mreq_strobe, 0);
    chk("fetch_addr_ok", {bus.iresp_addr_ok, bus.dresp_addr_ok}, 2'b10);
    push(1'b0, 1'b1, 64'h1111_2222);
    nxt();
    bus.mresp_valid = 1'b1; bus.mresp_data = 64'h1111_2222_3333_4444;
    smp(); chk("fetch_wait_addr_ok", bus.iresp_addr_ok, 0);
    chk("fetch_wait_mreq_valid", bus.mreq_valid, 0);
    nxt();
    bus.mresp_valid = 1'b0;
    nxt();
    bus.ireq_valid = 1'b0;
    nxt(); nxt();

    // Data write with three stall cycles
    bus.mreq_ready = 1'b0; bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h8000_1000;
    bus.dreq_size = 3'd3; bus.dreq_strobe = 8'hFF; bus.dreq_data = 64'hDEAD_BEEF_0000_0001;
    nxt();
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("wr_stall_mreq_valid", bus.mreq_valid, 1);
      chk("wr_stall_mreq_addr", bus.mreq_addr, 64'h8000_1000);
      chk("wr_stall_mreq_strobe", bus.mreq_strobe, 8'hFF);
      chk("wr_stall_mreq_wdata", bus.mreq_wdata, 64'hDEAD_BEEF_0000_0001);
      chk("wr_stall_mreq_size", bus.mreq_size, 3);
      chk("wr_stall_addr_ok", bus.dresp_addr_ok, 0);
      nxt();
    end
    bus.mreq_ready = 1'b1;
    smp(); chk("wr_addr_ok", {bus.iresp_addr_ok, bus.dresp_addr_ok}, 2'b01);
    push(1'b1, 1'b0, 64'd0);
    nxt();
    bus.mreq_ready = 1'b0; bus.mresp_valid = 1'b1; bus.mresp_data = 64'h5555_5555_5555_5555;
    smp(); chk("wr_wait_addr_ok", bus.dresp_addr_ok, 0);
    nxt();
    bus.mresp_valid = 1'b0;
    nxt();
    bus.dreq_valid = 1'b0; bus.dreq_strobe = '0; bus.dreq_data = '0;
    nxt(); nxt();

    // Contention over two grants, same-cycle responses
    bus.mreq_ready = 1'b1;
    bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0000;
    bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h8000_2000; bus.dreq_size = 3'd3;
    nxt();
    bus.mresp_valid = 1'b1; bus.mresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    smp();
    chk("cont1_addr_ok", {bus.iresp_addr_ok, bus.dresp_addr_ok}, 2'b01);
    chk("cont1_mreq_addr", bus.mreq_addr, 64'h8000_2000);
    push(1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    nxt();
    bus.mresp_valid = 1'b0;
    nxt();
    nxt();
    bus.mresp_valid = 1'b1; bus.mresp_data = 64'h0123_4567_89AB_CDEF;
    smp();
`ifdef ARB_ROUND_ROBIN_EN
    chk("cont2_addr_ok", {bus.iresp_addr_ok, bus.dresp_addr_ok}, 2'b10);
    chk("cont2_mreq_addr", bus.mreq_addr, 64'h8000_0000);
    chk("cont2_mreq_size", bus.mreq_size, 2);
    push(1'b0, 1'b1, 64'h89AB_CDEF);
`else
    chk("cont2_addr_ok", {bus.iresp_addr_ok, bus.dresp_addr_ok}, 2'b01);
    chk("cont2_mreq_addr", bus.mreq_addr, 64'h8000_2000);
    push(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
`endif
    nxt();
    bus.mresp_valid = 1'b0;
    nxt();
    bus.ireq_valid = 1'b0; bus.dreq_valid = 1'b0;
    nxt(); nxt();

    // Flush after addr_ok, then a dbus request granted right after
    bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0008;
    nxt();
    smp(); chk("flush_addr_ok", bus.iresp_addr_ok, 1);
    nxt();
    bus.ireq_valid = 1'b0;
    bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h8000_3000; bus.dreq_size = 3'd3;
    bus.mresp_valid = 1'b1; bus.mresp_data = 64'hFEDC_BA98_7654_3210;
    smp();
    chk("flush_wait_mreq_valid", bus.mreq_valid, 0);
    chk("flush_wait_daddr_ok", bus.dresp_addr_ok, 0);
    push(1'b0, 1'b1, 64'h7654_3210);
    nxt();
    bus.mresp_valid = 1'b0;
    nxt();
    smp(); chk("flush_idle_mreq_valid", bus.mreq_valid, 0);
    nxt();
    bus.mresp_valid = 1'b1; bus.mresp_data = 64'h0000_0000_CAFE_F00D;
    smp();
    chk("flush_next_daddr_ok", bus.dresp_addr_ok, 1);
    chk("flush_next_mreq_addr", bus.mreq_addr, 64'h8000_3000);
    push(1'b1, 1'b1, 64'h0000_0000_CAFE_F00D);
    nxt();
    bus.mresp_valid = 1'b0;
    nxt();
    bus.dreq_valid = 1'b0;
    nxt(); nxt();

    // Valid dropped in REQ before ready: back to IDLE silently
    bus.mreq_ready = 1'b0; bus.ireq_valid = 1'b1; bus.ireq_addr = 64'h8000_0010;
    nxt();
    smp(); chk("drop_req_mreq_valid", bus.mreq_valid, 1);
    nxt();
    bus.ireq_valid = 1'b0;
    smp();
    chk("drop_mreq_valid", bus.mreq_valid, 0);
    chk("drop_addr_ok", bus.iresp_addr_ok, 0);
    nxt();
    bus.mreq_ready = 1'b1;
    bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h8000_4000; bus.dreq_strobe = 8'h0F;
    bus.dreq_data = 64'h1234;
    smp(); chk("drop_idle_mreq_valid", bus.mreq_valid, 0);
    nxt();
    bus.mresp_valid = 1'b1; bus.mresp_data = 64'h7777_0000_0000_7777;
    smp();
    chk("drop_next_daddr_ok", bus.dresp_addr_ok, 1);
    chk("drop_next_strobe", bus.mreq_strobe, 8'h0F);
    push(1'b1, 1'b0, 64'd0);
    nxt();
    bus.mresp_valid = 1'b0;
    nxt();
    bus.dreq_valid = 1'b0; bus.dreq_strobe = '0; bus.dreq_data = '0;
    nxt(); nxt();

    // Reset while in WAIT, then a stale response
    bus.dreq_valid = 1'b1; bus.dreq_addr = 64'h8000_5000; bus.dreq_size = 3'd3;
    nxt();
    smp(); chk("rstw_addr_ok", bus.dresp_addr_ok, 1);
    nxt();
    rst_n = 1'b0; bus.dreq_valid = 1'b0; bus.mreq_ready = 1'b0;
    nxt();
    rst_n = 1'b1; bus.mresp_valid = 1'b1; bus.mresp_data = 64'h9999_9999_9999_9999;
    smp();
    chk("rstw_mreq_valid", bus.mreq_valid, 0);
    chk("rstw_dresp_data", bus.dresp_data, 0);
    nxt();
    bus.mresp_valid = 1'b0;
    smp();
    chk("rstw_data_ok", {bus.iresp_data_ok, bus.dresp_data_ok}, 0);
    chk("rstw_stale_dresp_data", bus.dresp_data, 0);
    chk("rstw_stale_iresp_data", bus.iresp_data, 0);
    chk("rstw_stale_mreq_addr", bus.mreq_addr, 0);
    nxt(); nxt();

    smp();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the core's instruction bus and data bus. It sits between `core` and the memory/cache interface. It grants one outstanding transaction at a time, converts the downstream valid/ready request + response-valid protocol into the ibus/dbus `addr_ok`/`data_ok` handshakes, and registers returned data. Arbitration is fixed dbus-priority, or round-robin when compiled with the configuration macro.

## Interface
Parameters:
- `ADDR_W`, 64, address width on all buses
- `DATA_W`, 64, downstream data width; dbus data width
- `INST_W`, 32, ibus instruction width; `DATA_W` must be 2×`INST_W`

Ports:
- `clk`  in  1  single clock; everything is on the rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `ireq_valid`  in  1  instruction fetch request; held until `iresp_data_ok`
- `ireq_addr`  in  ADDR_W  fetch address, 4-byte aligned
- `iresp_addr_ok`  out  1  fetch request accepted downstream (1-cycle pulse)
- `iresp_data_ok`  out  1  fetch data valid (1-cycle pulse)
- `iresp_data`  out  INST_W  fetched instruction
- `dreq_valid`  in  1  data request; held until `dresp_data_ok`
- `dreq_addr`  in  ADDR_W  data address
- `dreq_size`  in  3  log2 bytes (0..3)
- `dreq_strobe`  in  DATA_W/8  byte enables; nonzero means write
- `dreq_data`  in  DATA_W  write data
- `dresp_addr_ok`  out  1  data request accepted (1-cycle pulse)
- `dresp_data_ok`  out  1  data response valid (1-cycle pulse)
- `dresp_data`  out  DATA_W  read data (undefined for writes)
- `mreq_valid`  out  1  downstream request valid
- `mreq_ready`  in  1  downstream accepts the request this cycle
- `mreq_addr`  out  ADDR_W  downstream address
- `mreq_size`  out  3  downstream size; 2 for fetches
- `mreq_strobe`  out  DATA_W/8  downstream byte enables; 0 for fetches
- `mreq_wdata`  out  DATA_W  downstream write data
- `mresp_valid`  in  1  downstream response valid (1 cycle)
- `mresp_data`  in  DATA_W  downstream read data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. A 1-bit `owner` register holds I=0 / D=1.
- **IDLE**
  - With no valid request, stay in IDLE.
  - Otherwise pick an owner (rules below), latch it, and go to REQ.
- **REQ**
  - Drive `mreq_*` combinationally from the owner's live request fields. The requester holds them stable.
  - On `mreq_ready`, pulse the owner's `addr_ok` in the same cycle and go to WAIT.
- **WAIT**
  - On `mresp_valid`, register the data and go to RESP.
  - If `mresp_valid` arrives in the same cycle as the `mreq_ready` handshake (REQ), go straight to RESP with the data captured.
- **RESP**
  - Pulse the owner's `data_ok` for one cycle and go to IDLE.
- **Fetch data select:** `iresp_data` = `rdata_q[63:32]` if the latched `ireq_addr[2]`=1, else `rdata_q[31:0]`. `dresp_data` = `rdata_q` unshifted.
- **Priority without the macro:** dbus always wins when both requests are valid.
- **Dropped valid:** if the owner drops `valid` after `addr_ok` (pipeline flush), the downstream transaction still completes and `data_ok` still pulses. The requester discards it.
- **Dropped valid in REQ:** if the owner drops `valid` while in REQ before `mreq_ready`, return to IDLE with no pulses. `mreq_valid` falls in that cycle.
- A non-owner's request is ignored until the FSM returns to IDLE.

## Timing
- **Reset** (`rst_n`=0 at a clock edge), taking effect at the next edge:
  - state = IDLE, `owner` = 0, `rdata_q` = 0, `rr_last` = 0.
  - All outputs are 0: `mreq_valid`, all `addr_ok`/`data_ok`, `iresp_data`, `dresp_data`, and `mreq_*` fields.
- **Reset mid-transaction:** abandon the transaction. Later `mresp_valid` pulses arriving in IDLE are ignored.
- **Outputs:** `mreq_valid` = (state == REQ && owner's `valid`). `addr_ok` is combinational from `mreq_ready`. `data_ok` and the data outputs are registered.
- **Best-case latency with `mreq_ready` tied high**, measured from `req_valid` rising in IDLE at cycle 0:
  - cycle 1: REQ; `addr_ok` pulses.
  - The earliest `mresp_valid` is in that same cycle 1.
  - cycle 2: `data_ok` pulses.
- **Back-to-back:** the next grant's IDLE is cycle 3, so throughput is at most one transaction per 3 cycles.

## Configuration
- `ARB_ROUND_ROBIN_EN`
  - **Defined:** on contention in IDLE, grant the requester not served last, tracked by the 1-bit `rr_last` register, which is updated on every `data_ok`. With no contention, grant whichever request is valid.
  - **Undefined:** fixed dbus priority; `rr_last` is not present.

## Test plan
- **Single fetch:** `ireq_valid`=1, `ireq_addr`=0x8000_0004; `mresp_data`=0x1111_2222_3333_4444 one cycle after acceptance.
  - Required: `iresp_addr_ok` pulse, `mreq_size`=2, `mreq_strobe`=0.
  - Required: `iresp_data_ok` with `iresp_data`=0x1111_2222.
- **Data write:** `dreq_addr`=0x8000_1000, `strobe`=0xFF, `data`=0xDEAD_BEEF_0000_0001, `mreq_ready` held low for 3 cycles.
  - Required: `mreq_*` stable all 3 cycles, `dresp_addr_ok` on the 4th, then `dresp_data_ok` after `mresp_valid`.
- **Contention, both valid in IDLE for two transactions:**
  - Without macro: order D, D while dreq stays valid.
  - With `ARB_ROUND_ROBIN_EN`: order D then I (`rr_last` = 0 after reset implies ibus was last).
- **Flush:** drop `ireq_valid` after `iresp_addr_ok`.
  - Required: `iresp_data_ok` still pulses once; the FSM returns to IDLE; a following dreq is granted in the next cycle.
- **Reset in WAIT:** assert `rst_n`=0 for 1 cycle in WAIT, then deliver a stale `mresp_valid`.
  - Required: no `data_ok` pulse, all outputs 0, state IDLE.
- **Same-cycle response:** `mreq_ready` and `mresp_valid` both high in REQ.
  - Required: `data_ok` on the next cycle with the correct data.
